// File: rtl/hazard_stall_controller.sv
// Purpose : ID/EX sequencing control. Handles load-use interlock, HI/LO interlock
//           around the multi-cycle MDU, and wrong-path flush on a taken branch in EX.
//           Owns the MDU busy sequencer and a saturating stall-cycle counter.
// Latency : stall/flush/enable outputs are combinational from the same cycle's
//           inputs. The MDU runs start(t) -> BUSY t+1..t+N -> DONE t+N+1.
// Backpressure: a stall freezes PC and IF/ID and injects a bubble into ID/EX.
//           A taken branch overrides any stall.
// Ports   : clk/rst (async, active-high); ID_* describe the instruction in ID;
//           EX_* describe the instruction in EX. PC_Write/IF_ID_Write/IF_ID_Flush/
//           ID_EX_Flush drive the pipeline registers. MD_Start/MD_Busy/MD_Done
//           drive the MDU. StallCount counts stalled cycles and saturates.
module hazard_stall_controller #(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic        ID_UsesHiLo,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_WriteReg,
   input  logic        EX_MDStart,
   input  logic        EX_MDIsDiv,
   input  logic        EX_BranchTaken,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Flush,
   output logic        MD_Start,
   output logic        MD_Busy,
   output logic        MD_Done,
   output logic [15:0] StallCount
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   // The counter holds "remaining busy cycles minus one", so it is loaded with N-1.
   localparam logic [CNT_W-1:0] LP_MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [15:0]      r_stall_cnt;

   logic             w_load_use;
   logic             w_md_stall;
   logic             w_stall;
   logic             w_launch;

   // A launch is accepted in IDLE or DONE. In BUSY it is ignored, because a
   // HI/LO user is held in ID for the whole operation.
   assign w_launch = EX_MDStart && (r_state != S_BUSY);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (EX_MDStart) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = EX_MDIsDiv ? LP_DIV_LOAD : LP_MULT_LOAD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Hazard detection. Register 0 is never a real dependency.
   assign w_load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                       ((ID_UsesRs && (EX_WriteReg == ID_rs)) ||
                        (ID_UsesRt && (EX_WriteReg == ID_rt)));
   assign w_md_stall = ID_UsesHiLo && ((r_state == S_BUSY) || EX_MDStart);
   assign w_stall    = w_load_use || w_md_stall;

   // Output logic. While reset is held the pipeline runs free and nothing launches.
   always_comb begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      MD_Start    = 1'b0;
      MD_Busy     = (r_state == S_BUSY);
      MD_Done     = (r_state == S_DONE);
      if (!rst) begin
         MD_Start = w_launch;
         if (EX_BranchTaken) begin
            // The ID instruction is wrong-path, so any stall it would cause is moot.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end else if (w_stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end
      end
   end

   // Saturating stall-cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= 16'd0;
      end else if (!PC_Write && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Purpose : directed self-checking bench for hazard_stall_controller.
// Latency : inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
// Backpressure: none; the bench drives the EX/ID fields directly.
module tb_hazard_stall_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        ID_UsesRs;
   logic        ID_UsesRt;
   logic        ID_UsesHiLo;
   logic        EX_MemRead;
   logic [4:0]  EX_WriteReg;
   logic        EX_MDStart;
   logic        EX_MDIsDiv;
   logic        EX_BranchTaken;
   logic        PC_Write;
   logic        IF_ID_Write;
   logic        IF_ID_Flush;
   logic        ID_EX_Flush;
   logic        MD_Start;
   logic        MD_Busy;
   logic        MD_Done;
   logic [15:0] StallCount;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_stall_controller #(
      .MULT_CYCLES(4),
      .DIV_CYCLES (32),
      .CNT_W      (6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ID_rs         (ID_rs),
      .ID_rt         (ID_rt),
      .ID_UsesRs     (ID_UsesRs),
      .ID_UsesRt     (ID_UsesRt),
      .ID_UsesHiLo   (ID_UsesHiLo),
      .EX_MemRead    (EX_MemRead),
      .EX_WriteReg   (EX_WriteReg),
      .EX_MDStart    (EX_MDStart),
      .EX_MDIsDiv    (EX_MDIsDiv),
      .EX_BranchTaken(EX_BranchTaken),
      .PC_Write      (PC_Write),
      .IF_ID_Write   (IF_ID_Write),
      .IF_ID_Flush   (IF_ID_Flush),
      .ID_EX_Flush   (ID_EX_Flush),
      .MD_Start      (MD_Start),
      .MD_Busy       (MD_Busy),
      .MD_Done       (MD_Done),
      .StallCount    (StallCount)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
      ID_UsesHiLo = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
      EX_MDStart = 1'b0; EX_MDIsDiv = 1'b0; EX_BranchTaken = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      // Reset held, with a load-use pattern present: outputs must stay free-running.
      EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_rs = 5'd8; ID_UsesRs = 1'b1;
      tick();
      #1;
      chk1 ("rst_pc_write",  PC_Write,    1'b1);
      chk1 ("rst_ifid_wr",   IF_ID_Write, 1'b1);
      chk1 ("rst_idex_fl",   ID_EX_Flush, 1'b0);
      chk1 ("rst_md_busy",   MD_Busy,     1'b0);
      chk1 ("rst_md_done",   MD_Done,     1'b0);
      chk16("rst_stallcnt",  StallCount,  16'd0);
      tick();
      chk16("rst_stallcnt2", StallCount,  16'd0);

      // Load-use on rs
      rst = 1'b0;
      #1;
      chk1 ("lu_pc_write",   PC_Write,    1'b0);
      chk1 ("lu_ifid_wr",    IF_ID_Write, 1'b0);
      chk1 ("lu_idex_fl",    ID_EX_Flush, 1'b1);
      chk1 ("lu_ifid_fl",    IF_ID_Flush, 1'b0);
      tick();
      chk16("lu_cnt1",       StallCount,  16'd1);

      // Destination $0 never interlocks
      EX_WriteReg = 5'd0; ID_rs = 5'd0;
      #1;
      chk1 ("lu_r0_pc",      PC_Write,    1'b1);
      tick();
      chk16("lu_r0_cnt",     StallCount,  16'd1);

      // rt match but rt not read, then rt read
      EX_WriteReg = 5'd9; ID_rt = 5'd9; ID_rs = 5'd3; ID_UsesRs = 1'b1; ID_UsesRt = 1'b0;
      #1;
      chk1 ("rt_unused_pc",  PC_Write,    1'b1);
      ID_UsesRt = 1'b1;
      #1;
      chk1 ("rt_used_pc",    PC_Write,    1'b0);
      tick();
      chk16("rt_used_cnt",   StallCount,  16'd2);

      // Taken branch overrides the load-use stall
      EX_BranchTaken = 1'b1;
      #1;
      chk1 ("br_ifid_fl",    IF_ID_Flush, 1'b1);
      chk1 ("br_idex_fl",    ID_EX_Flush, 1'b1);
      chk1 ("br_pc_write",   PC_Write,    1'b1);
      chk1 ("br_ifid_wr",    IF_ID_Write, 1'b1);
      tick();
      chk16("br_cnt",        StallCount,  16'd2);

      // Multiply, N=4: stall t..t+4, DONE at t+5
      idle_inputs();
      EX_MDStart = 1'b1; EX_MDIsDiv = 1'b0; ID_UsesHiLo = 1'b1;
      #1;
      chk1 ("mul_start",     MD_Start,    1'b1);
      chk1 ("mul_busy_t",    MD_Busy,     1'b0);
      chk1 ("mul_pc_t",      PC_Write,    1'b0);
      tick();
      EX_MDStart = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk1("mul_busy",    MD_Busy,     1'b1);
         chk1("mul_nodone",  MD_Done,     1'b0);
         chk1("mul_stall",   PC_Write,    1'b0);
         tick();
      end
      chk1 ("mul_done",      MD_Done,     1'b1);
      chk1 ("mul_done_nb",   MD_Busy,     1'b0);
      chk1 ("mul_release",   PC_Write,    1'b1);
      chk16("mul_cnt",       StallCount,  16'd7);
      tick();
      chk1 ("mul_idle_done", MD_Done,     1'b0);
      chk1 ("mul_idle_busy", MD_Busy,     1'b0);
      chk16("mul_cnt2",      StallCount,  16'd7);

      // Divide, N=32: 33 stall cycles, DONE at t+33
      EX_MDStart = 1'b1; EX_MDIsDiv = 1'b1;
      #1;
      chk1 ("div_start",     MD_Start,    1'b1);
      tick();
      EX_MDStart = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         #1;
         chk1("div_busy",    MD_Busy,     1'b1);
         chk1("div_nodone",  MD_Done,     1'b0);
         tick();
      end
      chk1 ("div_done",      MD_Done,     1'b1);
      chk16("div_cnt",       StallCount,  16'd40);

      // Second start in DONE goes straight back to BUSY
      EX_MDStart = 1'b1; EX_MDIsDiv = 1'b1;
      #1;
      chk1 ("re_start",      MD_Start,    1'b1);
      chk1 ("re_stall",      PC_Write,    1'b0);
      tick();
      EX_MDStart = 1'b0;
      chk1 ("re_busy",       MD_Busy,     1'b1);
      chk16("re_cnt",        StallCount,  16'd41);

      // Advance to counter==10 (31 on the first busy cycle), then reset mid-cycle
      repeat (21) tick();
      chk1 ("pre_rst_busy",  MD_Busy,     1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk1 ("arst_busy",     MD_Busy,     1'b0);
      chk1 ("arst_done",     MD_Done,     1'b0);
      chk16("arst_cnt",      StallCount,  16'd0);
      rst = 1'b0;
      #1;
      chk1 ("arst_rel_pc",   PC_Write,    1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("arst_no_done", MD_Done,    1'b0);
         chk1("arst_no_busy", MD_Busy,    1'b0);
         chk1("arst_no_stal", PC_Write,   1'b1);
      end
      chk16("arst_cnt2",     StallCount,  16'd0);

      // Saturation: 65540 stalled edges
      idle_inputs();
      EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_rs = 5'd8; ID_UsesRs = 1'b1;
      repeat (65534) tick();
      chk16("sat_fffe",      StallCount,  16'hFFFE);
      tick();
      chk16("sat_ffff",      StallCount,  16'hFFFF);
      repeat (5) tick();
      chk16("sat_hold",      StallCount,  16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
